clc_key: RTL and testbench
==========================

Name: clc_key

Overview:
- Sequential modular-exponentiation stage that computes the shared secret key = r_in^x mod p.
- Sits directly downstream of the public-value stage.
- r_in is the partner's public value (R1 or R2); x is the local private exponent.
- Uses square-and-multiply with bit-serial interleaved modular multiplication, so no 32x32 multiplier and no divider is needed. Latency is fixed and data-independent.

Parameters:
- W, 32, operand width (base, exponent, modulus, key).

Ports:
- clk   input   1   system clock, rising edge.
- rst   input   1   reset, asynchronous, active-low.
- st    input   1   start request, sampled on the rising edge of clk.
- r_in  input   W   base (partner public value); any value, may be >= p.
- x     input   W   private exponent.
- p     input   W   modulus.
- key   output  W   result r_in^x mod p.
- busy  output  1   high while a computation is in progress.
- done  output  1   one-cycle completion pulse.
- err   output  1   high if the last accepted request had p == 0.

Behaviour:
- Reset: clk and rst use one clock. Reset is asynchronous and active-low. On reset, key=0, busy=0, done=0, err=0, state=IDLE, and all internal registers are 0. Asserting reset mid-operation aborts the computation with no done pulse.
- Handshake:
  - st is accepted only in IDLE. st while busy=1 is ignored.
  - On acceptance, r_in, x and p are latched; later input changes have no effect.
  - done pulses for exactly 1 cycle.
  - key and err are updated on the same edge that raises done, and hold until the next completion.
- States:
  - IDLE: wait for st.
  - RED: reduce the base.
  - EXP: exponent loop.
  - FIN: signal completion.
- IDLE, st=1, p==0: go to FIN. key<=0, err<=1. done is asserted 1 cycle after the accepting edge.
- IDLE, st=1, p!=0: go to RED with busy=1.
  - res <= 1, or 0 if p==1.
  - bit counter <= W-1.
- RED, W cycles: b = r_in*1 mod p via the interleaved multiply, scanning the multiplier MSB first.
  - Each cycle: acc <= 2*acc + (bit ? multiplicand : 0), then subtract p while acc >= p (at most twice).
  - acc is W+2 bits internally; the result after each step is < p.
- EXP: W rounds of W cycles each, one round per exponent bit, LSB first. Two interleaved multipliers run in parallel each round:
  - sq = b*b mod p.
  - mu = res*b mod p.
  - End of round: b <= sq; res <= mu if the current bit of x is 1, otherwise res is unchanged.
  - Exponent register shifts right by 1.
- Latency: exactly W rounds (not terminated early). After the final round, go to FIN.
- FIN: key <= res, err <= 0 (err <= 1 on the p==0 path), done=1, busy=0, return to IDLE.
- Total latency for p!=0: done is high during the cycle that begins W + W*W + 1 edges after the accepting edge (1057 for W=32).
- A new st may be accepted on the edge that returns the block to IDLE, i.e. the cycle after done.
- Boundary results:
  - x==0 gives key = 1 mod p.
  - r_in mod p == 0 with x!=0 gives key = 0.
  - p==1 always gives key = 0.
  - Intermediate values never exceed W+2 bits; no overflow at p up to 2^W-1.

Test Plan:
- Reset during RED and during EXP -> busy=0, done never pulses; the next request completes normally.
- r_in=19, x=6, p=23 -> done after 1057 cycles, key=2, err=0. Then r_in=8, x=15, p=23 -> key=2 (matching shared key).
- r_in=28 (>= p), x=6, p=23 -> key=8.
- x=0, r_in=123, p=97 -> key=1. Then p=1, any r_in/x -> key=0.
- r_in=0xFFFFFFFF, x=2, p=0xFFFFFFFB -> key=16.
- p=0 -> err=1, key=0, done 1 cycle after st.
- Handshake: st pulsed while busy -> ignored, and the original result is unchanged. Back-to-back st the cycle after done -> accepted. Inputs changed mid-run -> no effect on the result.

Source files
------------

// File: rtl/clc_key_if.sv
// Request/response bundle for the clc_key modular-exponentiation stage.
// The requester drives the master side and clc_key is the slave.
interface clc_key_if #(
  parameter int W = 32
);
  logic         st;
  logic [W-1:0] r_in;
  logic [W-1:0] x;
  logic [W-1:0] p;
  logic [W-1:0] key;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output st, r_in, x, p,
    input  key, busy, done, err
  );

  modport slave (
    input  st, r_in, x, p,
    output key, busy, done, err
  );
endinterface

// File: rtl/clc_key.sv
// Shared-key stage: key = r_in^x mod p, computed by square-and-multiply over
// bit-serial interleaved modular multipliers, with a fixed latency.
module clc_key #(
  parameter int W = 32
) (
  input  logic      clk,
  input  logic      rst,
  clc_key_if.slave  bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RED, EXP, FIN} state_t;

  state_t         state, nxt;
  logic [W-1:0]   r_q, x_q, p_q, b_q, res_q;
  logic [W-1:0]   acc_sq, acc_mu, key_q;
  logic [CW-1:0]  bcnt, rcnt;
  logic           done_q, err_q, perr_q;
  logic           busy_c;
  logic [W-1:0]   mc_sq;
  logic           bit_sq;
  logic [W-1:0]   sq_nxt, mu_nxt;

  // One interleaved step: 2*acc + (bt ? mc : 0), then at most two subtractions of m.
  // acc, mc < m keeps the sum below 3m, which fits in W+2 bits.
  function automatic logic [W-1:0] mm_step(input logic [W-1:0] acc,
                                           input logic [W-1:0] mc,
                                           input logic         bt,
                                           input logic [W-1:0] m);
    logic [W+1:0] t;
    t = {1'b0, acc, 1'b0} + (bt ? {2'b00, mc} : {(W+2){1'b0}});
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (bus.st) nxt = (bus.p == '0) ? FIN : RED;
      RED:  if (bcnt == '0) nxt = EXP;
      EXP:  if (bcnt == '0 && rcnt == '0) nxt = FIN;
      FIN:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // RED reduces the base as 1 * r_in: multiplicand 1, multiplier r_in, so the
  // sum stays below 2p even when r_in >= p.
  always_comb begin
    busy_c = 1'b0;
    mc_sq  = b_q;
    bit_sq = b_q[bcnt];
    unique case (state)
      IDLE: busy_c = 1'b0;
      RED: begin
        busy_c = 1'b1;
        mc_sq  = W'(1);
        bit_sq = r_q[bcnt];
      end
      EXP:  busy_c = 1'b1;
      FIN:  busy_c = 1'b1;
      default: busy_c = 1'b0;
    endcase
  end

  assign sq_nxt = mm_step(acc_sq, mc_sq, bit_sq, p_q);
  assign mu_nxt = mm_step(acc_mu, b_q, res_q[bcnt], p_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= '0;
      x_q    <= '0;
      p_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      acc_sq <= '0;
      acc_mu <= '0;
      key_q  <= '0;
      bcnt   <= '0;
      rcnt   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      done_q <= (state == FIN);
      unique case (state)
        IDLE: begin
          if (bus.st) begin
            r_q    <= bus.r_in;
            x_q    <= bus.x;
            p_q    <= bus.p;
            b_q    <= '0;
            acc_sq <= '0;
            acc_mu <= '0;
            bcnt   <= CW'(W - 1);
            rcnt   <= CW'(W - 1);
            perr_q <= (bus.p == '0);
            res_q  <= (bus.p == '0 || bus.p == W'(1)) ? '0 : W'(1);
          end
        end
        RED: begin
          if (bcnt == '0) begin
            b_q    <= sq_nxt;
            acc_sq <= '0;
            bcnt   <= CW'(W - 1);
          end else begin
            acc_sq <= sq_nxt;
            bcnt   <= bcnt - 1'b1;
          end
        end
        EXP: begin
          if (bcnt == '0) begin
            b_q    <= sq_nxt;
            if (x_q[0]) res_q <= mu_nxt;
            x_q    <= x_q >> 1;
            acc_sq <= '0;
            acc_mu <= '0;
            bcnt   <= CW'(W - 1);
            rcnt   <= rcnt - 1'b1;
          end else begin
            acc_sq <= sq_nxt;
            acc_mu <= mu_nxt;
            bcnt   <= bcnt - 1'b1;
          end
        end
        FIN: begin
          key_q <= res_q;
          err_q <= perr_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.key  = key_q;
  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_clc_key.sv
// Directed bench for clc_key: hand-computed keys, latency, handshake and reset abort.
module tb_clc_key;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clc_key_if #(.W(32)) bus();
  clc_key #(.W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int failures = 0;
  logic [31:0] prev_key = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] r, input logic [31:0] xe, input logic [31:0] m);
    bus.r_in = r;
    bus.x    = xe;
    bus.p    = m;
    bus.st   = 1'b1;
    @(posedge clk);
    #1;
    bus.st   = 1'b0;
  endtask

  // Starts a request, optionally disturbs it mid-run, waits for done (bounded).
  task automatic run(input string tag, input logic [31:0] r, input logic [31:0] xe,
                     input logic [31:0] m, input logic [31:0] exp_key, input logic exp_err,
                     input int exp_lat, input bit disturb);
    int lat;
    start(r, xe, m);
    chk({tag, ".busy_acc"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, ".done_acc"}, {31'd0, bus.done}, 32'd0);
    chk({tag, ".key_hold"}, bus.key, prev_key);
    lat = 0;
    while (lat < 1200) begin
      if (disturb && lat == 100) begin
        bus.st   = 1'b1;
        bus.r_in = 32'd5;
        bus.x    = 32'd7;
        bus.p    = 32'd11;
      end
      if (disturb && lat == 101) bus.st = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".key"}, bus.key, exp_key);
    chk({tag, ".err"}, {31'd0, bus.err}, {31'd0, exp_err});
    chk({tag, ".busy_done"}, {31'd0, bus.busy}, 32'd0);
    prev_key = exp_key;
  endtask

  task automatic reset_abort(input string tag);
    int pulses;
    rst = 1'b0;
    #1;
    chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, ".key"}, bus.key, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk({tag, ".no_done"}, pulses, 0);
    prev_key = 32'd0;
  endtask

  initial begin
    rst      = 1'b0;
    bus.st   = 1'b0;
    bus.r_in = '0;
    bus.x    = '0;
    bus.p    = '0;
    #2;
    chk("reset.key", bus.key, 32'd0);
    chk("reset.busy", {31'd0, bus.busy}, 32'd0);
    chk("reset.done", {31'd0, bus.done}, 32'd0);
    chk("reset.err", {31'd0, bus.err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    run("r19x6", 32'd19, 32'd6, 32'd23, 32'd2, 1'b0, 1057, 1'b0);
    run("r8x15_b2b", 32'd8, 32'd15, 32'd23, 32'd2, 1'b0, 1057, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    run("r28_disturb", 32'd28, 32'd6, 32'd23, 32'd8, 1'b0, 1057, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    run("x0", 32'd123, 32'd0, 32'd97, 32'd1, 1'b0, 1057, 1'b0);
    run("p1", 32'hDEADBEEF, 32'h00001234, 32'd1, 32'd0, 1'b0, 1057, 1'b0);
    run("bigp", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFB, 32'd16, 1'b0, 1057, 1'b0);
    run("rmod0", 32'd46, 32'd3, 32'd23, 32'd0, 1'b0, 1057, 1'b0);
    run("p0", 32'd5, 32'd3, 32'd0, 32'd0, 1'b1, 1, 1'b0);
    run("after_p0", 32'd19, 32'd6, 32'd23, 32'd2, 1'b0, 1057, 1'b0);

    start(32'd19, 32'd6, 32'd23);
    repeat (10) @(posedge clk);
    #1;
    reset_abort("rst_red");
    run("post_rst_red", 32'd8, 32'd15, 32'd23, 32'd2, 1'b0, 1057, 1'b0);

    start(32'd19, 32'd6, 32'd23);
    repeat (300) @(posedge clk);
    #1;
    reset_abort("rst_exp");
    run("post_rst_exp", 32'd28, 32'd6, 32'd23, 32'd8, 1'b0, 1057, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
